// File: rtl/cic_sched.sv
// rtl/cic_sched.sv - multichannel CIC integrate/dump scheduler
// Sequences one integrator slot per cycle per sample set and presents decimated outputs per channel.
module cic_sched #(
  parameter int DECIM_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_en_i,
  input  logic [1:0]         cfg_nch_i,
  input  logic [DECIM_W-1:0] cfg_decim_i,
  input  logic               sample_valid_i,
  output logic               sample_ready_o,
  output logic               integ_en_o,
  output logic               integ_clr_o,
  output logic [1:0]         integ_sel_o,
  output logic               out_valid_o,
  output logic [1:0]         out_ch_o,
  input  logic               out_ready_i,
  output logic               overrun_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_INTEG,
    S_DUMP
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         nch_q, nch_d;
  logic [1:0]         ch_q, ch_d;
  logic [DECIM_W-1:0] decim_q, decim_d;
  logic [DECIM_W-1:0] dcnt_q, dcnt_d;
  logic               ovr_q, ovr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      nch_q   <= '0;
      ch_q    <= '0;
      decim_q <= '0;
      dcnt_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nch_q   <= nch_d;
      ch_q    <= ch_d;
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    nch_d          = nch_q;
    ch_d           = ch_q;
    decim_d        = decim_q;
    dcnt_d         = dcnt_q;
    ovr_d          = ovr_q;
    sample_ready_o = 1'b0;
    integ_en_o     = 1'b0;
    integ_clr_o    = 1'b0;
    integ_sel_o    = 2'd0;
    out_valid_o    = 1'b0;
    out_ch_o       = 2'd0;
    busy_o         = (state_q != S_IDLE);
    // The sticky flag survives a disable but is hidden while idle.
    overrun_o      = ovr_q && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (cfg_en_i) begin
          nch_d   = cfg_nch_i;
          decim_d = cfg_decim_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        integ_clr_o = 1'b1;
        ch_d        = 2'd0;
        dcnt_d      = '0;
        // A sample arriving during the clear itself is still an overrun.
        ovr_d       = sample_valid_i;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) begin
          ch_d    = 2'd0;
          state_d = S_INTEG;
        end
      end
      S_INTEG: begin
        integ_en_o  = 1'b1;
        integ_sel_o = ch_q;
        if (sample_valid_i) ovr_d = 1'b1;
        if (ch_q == nch_q) begin
          ch_d = 2'd0;
          if (dcnt_q == decim_q) begin
            dcnt_d  = '0;
            state_d = S_DUMP;
          end else begin
            dcnt_d  = dcnt_q + {{(DECIM_W-1){1'b0}}, 1'b1};
            state_d = S_WAIT;
          end
        end else begin
          ch_d = ch_q + 2'd1;
        end
      end
      S_DUMP: begin
        out_valid_o = 1'b1;
        out_ch_o    = ch_q;
        integ_sel_o = ch_q;
        if (sample_valid_i) ovr_d = 1'b1;
        if (out_ready_i) begin
          if (ch_q == nch_q) begin
            ch_d    = 2'd0;
            state_d = S_WAIT;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable overrides any sample or handshake decision made above.
    if (state_q != S_IDLE && !cfg_en_i) begin
      state_d = S_IDLE;
      ch_d    = 2'd0;
      dcnt_d  = '0;
    end
  end

endmodule

// File: tb/tb_cic_sched.sv
// tb/tb_cic_sched.sv - scoreboard bench for cic_sched
// Expected integrator slots and output channels come from a queue-based model of the schedule.
module tb_cic_sched;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       cfg_en_i = 1'b0;
  logic [1:0] cfg_nch_i = 2'd0;
  logic [9:0] cfg_decim_i = 10'd0;
  logic       sample_valid_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic       sample_ready_o, integ_en_o, integ_clr_o, out_valid_o, overrun_o, busy_o;
  logic [1:0] integ_sel_o, out_ch_o;

  cic_sched #(.DECIM_W(10)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_nch_i(cfg_nch_i),
    .cfg_decim_i(cfg_decim_i), .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .integ_en_o(integ_en_o), .integ_clr_o(integ_clr_o), .integ_sel_o(integ_sel_o),
    .out_valid_o(out_valid_o), .out_ch_o(out_ch_o), .out_ready_i(out_ready_i),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int sel;} integ_t;
  integ_t iq[$];
  int     dq[$];
  integ_t it;
  int     cyc = 0;
  int     vectors = 0, miscompares = 0;
  bit     mon_on = 1'b0, rnd_ready = 1'b0;
  int     m_nch, m_decim, m_nacc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " sample_ready_o"}, sample_ready_o, 0);
    chk({tag, " integ_en_o"}, integ_en_o, 0);
    chk({tag, " integ_clr_o"}, integ_clr_o, 0);
    chk({tag, " integ_sel_o"}, integ_sel_o, 0);
    chk({tag, " out_valid_o"}, out_valid_o, 0);
    chk({tag, " out_ch_o"}, out_ch_o, 0);
    chk({tag, " overrun_o"}, overrun_o, 0);
    chk({tag, " busy_o"}, busy_o, 0);
  endtask

  // Called from IDLE; returns one cycle after CLEAR, i.e. in WAIT.
  task automatic enable(input int nch, input int decim);
    cfg_nch_i = 2'(nch);
    cfg_decim_i = 10'(decim);
    cfg_en_i = 1'b1;
    m_nch = nch;
    m_decim = decim;
    m_nacc = 0;
    iq.delete();
    dq.delete();
    step();
    chk("clear pulse", integ_clr_o, 1);
    chk("ready in clear", sample_ready_o, 0);
    cfg_nch_i = 2'($urandom_range(0, 3));
    cfg_decim_i = 10'($urandom_range(0, 1023));
    step();
    chk("clear one cycle", integ_clr_o, 0);
    chk("ready after clear", sample_ready_o, 1);
  endtask

  task automatic try_sample();
    sample_valid_i = 1'b1;
    if (sample_ready_o) begin
      for (int k = 0; k <= m_nch; k++) iq.push_back('{cyc + 1 + k, k});
      m_nacc++;
      if (m_nacc % (m_decim + 1) == 0)
        for (int k = 0; k <= m_nch; k++) dq.push_back(k);
    end
    step();
    sample_valid_i = 1'b0;
  endtask

  task automatic send_sample();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (sample_ready_o) begin
        try_sample();
        done = 1'b1;
      end else begin
        step();
      end
    end
    chk("sample_ready wait", done, 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (iq.size() == 0 && dq.size() == 0 && sample_ready_o) done = 1'b1;
      else step();
    end
    chk("drain to WAIT", done, 1);
  endtask

  task automatic disable_chk();
    cfg_en_i = 1'b0;
    step();
    chk("busy after disable", busy_o, 0);
    chk("out_valid after disable", out_valid_o, 0);
    iq.delete();
    dq.delete();
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("ready/valid exclusive", {31'd0, sample_ready_o & out_valid_o}, 0);
      chk("clr/en exclusive", {31'd0, integ_clr_o & integ_en_o}, 0);
      if (integ_en_o) begin
        if (iq.size() == 0) begin
          chk("unexpected integ_en_o", 1, 0);
        end else begin
          it = iq.pop_front();
          chk("integ cycle", cyc, it.cyc);
          chk("integ_sel_o", integ_sel_o, it.sel);
        end
      end else if (iq.size() > 0 && iq[0].cyc <= cyc) begin
        chk("integ_en_o missing", 0, 1);
        void'(iq.pop_front());
      end
      if (out_valid_o) chk("out_ch_o vs integ_sel_o", out_ch_o, integ_sel_o);
      if (out_valid_o && out_ready_i) begin
        if (dq.size() == 0) chk("unexpected dump", 1, 0);
        else chk("out_ch_o", out_ch_o, dq.pop_front());
      end
    end
  end

  initial begin
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    mon_on = 1'b1;
    step();
    check_all_zero("idle");

    // Four channels, decimate by 1, consumer always ready
    out_ready_i = 1'b1;
    enable(3, 0);
    send_sample();
    drain();
    disable_chk();

    // Two channels, decimate by 4: no dump before the fourth sample
    enable(1, 3);
    for (int s = 0; s < 3; s++) begin
      send_sample();
      repeat (3) step();
      chk("back to WAIT", sample_ready_o, 1);
      chk("no dump yet", out_valid_o, 0);
    end
    send_sample();
    drain();
    disable_chk();

    // Output held stable under backpressure
    enable(1, 0);
    out_ready_i = 1'b0;
    send_sample();
    for (int i = 0; i < 20 && !out_valid_o; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("held out_valid_o", out_valid_o, 1);
      chk("held out_ch_o", out_ch_o, 0);
      step();
    end
    out_ready_i = 1'b1;
    drain();
    disable_chk();

    // Overrun during INTEG is sticky and cleared by re-enable
    enable(3, 1);
    send_sample();
    sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    chk("overrun set", overrun_o, 1);
    step();
    chk("overrun sticky", overrun_o, 1);
    drain();
    chk("overrun after drain", overrun_o, 1);
    disable_chk();
    enable(3, 1);
    chk("overrun cleared", overrun_o, 0);
    disable_chk();

    // Disable mid-DUMP at channel 2 of 4
    enable(3, 0);
    send_sample();
    for (int i = 0; i < 20 && !(out_valid_o && out_ch_o == 2'd2); i++) step();
    chk("reached dump ch2", out_ch_o, 2);
    out_ready_i = 1'b0;
    disable_chk();
    out_ready_i = 1'b1;
    enable(3, 0);
    disable_chk();

    // Asynchronous reset mid-INTEG, then fresh enable straight after release
    enable(2, 1);
    send_sample();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async reset");
    mon_on = 1'b0;
    iq.delete();
    dq.delete();
    step();
    cfg_nch_i = 2'd1;
    cfg_decim_i = 10'd0;
    m_nch = 1;
    m_decim = 0;
    m_nacc = 0;
    rst_i = 1'b0;
    mon_on = 1'b1;
    step();
    chk("clear after reset release", integ_clr_o, 1);
    step();
    chk("ready after reset release", sample_ready_o, 1);
    send_sample();
    drain();
    disable_chk();

    // Randomized runs
    rnd_ready = 1'b1;
    for (int r = 0; r < 30; r++) begin
      enable(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 2) == 0 && sample_ready_o) try_sample();
        else step();
      end
      if ($urandom_range(0, 3) != 0) begin
        drain();
        chk("no overrun", overrun_o, 0);
      end
      disable_chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cic_sched.md
CIC_SCHED -- requirements
Module: cic_sched

Interface
REQ-001 Parameter: DECIM_W, default 10, width of decimation ratio config and counter.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous reset, active-high.
REQ-004 cfg_en_i  input  1  scheduler enable; low aborts and idles.
REQ-005 cfg_nch_i  input  2  active channel count minus 1 (0..3 -> 1..4 channels).
REQ-006 cfg_decim_i  input  DECIM_W  decimation ratio minus 1 (samples per output minus 1).
REQ-007 sample_valid_i  input  1  new input sample set (all channels) available this cycle.
REQ-008 sample_ready_o  output  1  scheduler can accept a sample set this cycle.
REQ-009 integ_en_o  output  1  integrator accumulate enable for slot integ_sel_o.
REQ-010 integ_clr_o  output  1  clear all four integrator slots.
REQ-011 integ_sel_o  output  2  integrator slot (channel) select.
REQ-012 out_valid_o  output  1  decimated output for channel out_ch_o is readable.
REQ-013 out_ch_o  output  2  channel being presented.
REQ-014 out_ready_i  input  1  consumer accepts current output.
REQ-015 overrun_o  output  1  sticky: sample_valid_i arrived while sample_ready_o low.
REQ-016 busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, CLEAR, WAIT, INTEG, DUMP.
REQ-018 IDLE: all outputs low; on cfg_en_i=1 latch cfg_nch_i and cfg_decim_i, go CLEAR.
REQ-019 CLEAR (exactly one cycle): integ_clr_o=1, decimation counter <= 0, channel counter <= 0, overrun_o <= 0; next WAIT.
REQ-020 WAIT: sample_ready_o=1; sample_valid_i=1 accepts the sample set, next INTEG with channel counter 0.
REQ-021 INTEG: integ_en_o=1, integ_sel_o=channel counter; one channel per cycle; sequence 0..nch, so INTEG lasts nch+1 cycles.
REQ-022 Latency: sample accepted in cycle t -> integ_en_o for channel k asserted in cycle t+1+k.
REQ-023 End of INTEG (channel==nch): if decimation counter==decim, counter <= 0 and go DUMP with channel 0; else counter increments, go WAIT.
REQ-024 decim=0: every accepted sample set produces a DUMP.
REQ-025 DUMP: out_valid_o=1, out_ch_o=integ_sel_o=channel counter, integ_en_o=0; outputs held stable until out_ready_i=1.
REQ-026 DUMP handshake: out_valid_o&out_ready_i completes channel; if channel==nch go WAIT, else channel increments and DUMP continues.
REQ-027 Channel counter never exceeds latched nch; no wrap to unused slots.
REQ-028 overrun_o: set when sample_valid_i=1 in CLEAR, INTEG or DUMP; sample dropped; integration state unaffected; cleared only by CLEAR or reset.
REQ-029 cfg_en_i=0 in any non-IDLE state: next state IDLE, counters reset, out_valid_o low next cycle; disable wins over simultaneous sample or handshake (handshake in that cycle counts as delivered to consumer).
REQ-030 cfg_nch_i/cfg_decim_i changes outside IDLE are ignored until next enable.
REQ-031 Re-enable always passes through CLEAR before any integration.
REQ-032 sample_ready_o and out_valid_o never high simultaneously; integ_clr_o and integ_en_o never high simultaneously.

Reset
REQ-033 rst_i=1 forces IDLE immediately, independent of clk_i; all outputs 0, decimation and channel counters 0, overrun_o 0, latched config 0.
REQ-034 Reset release mid-operation resumes from IDLE; first cycle with cfg_en_i=1 after release is treated as a fresh enable.

Verification
REQ-035 nch=3, decim=0, one sample: CLEAR 1 cycle, integ_en_o with sel 0,1,2,3 on 4 cycles, then DUMP out_ch_o 0..3 with out_ready_i=1 each cycle, back to WAIT.
REQ-036 nch=1, decim=3, 4 samples: DUMP occurs only after 4th sample; first three INTEG phases return to WAIT.
REQ-037 DUMP with out_ready_i held low 5 cycles: out_valid_o, out_ch_o=0 stable 5 cycles, advance on ready.
REQ-038 sample_valid_i pulsed during INTEG: overrun_o=1 sticky, integ_sel_o sequence unchanged; cleared after disable/re-enable CLEAR.
REQ-039 cfg_en_i dropped mid-DUMP at channel 2 of 4: out_valid_o=0 next cycle, busy_o=0; re-enable produces integ_clr_o pulse.
REQ-040 rst_i asserted mid-INTEG asynchronously: all outputs 0 before next clock edge.
